sram_sp_bw_init: RTL and testbench
==================================

Name: sram_sp_bw_init

Overview:
- Parametrised single-port synchronous SRAM behavioural model. It is the next generation of the fixed 128x64 macro models used by the pipeline caches.
- Features the macros lack:
  - power-on clear sequencer
  - ready handshake
  - configurable read latency (1 or 2)
  - deterministic output hold instead of random data
  - out-of-range address detection
- Sits under the I-cache/D-cache data and tag arrays. It replaces per-geometry copies of the macro.

Parameters:
- DATA_W, 128, word width in bits
- DEPTH, 64, number of words; need not be a power of two
- ADDR_W, 6, address width; must satisfy 2^ADDR_W >= DEPTH
- RD_LAT, 1, read latency in cycles; legal values 1 or 2; any other value is an elaboration error
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous reset, active-high
- CEN  input  1  chip enable, active-low
- WEN  input  1  write enable, active-low (0 = write, 1 = read)
- BWEN  input  DATA_W  per-bit write mask, active-low (0 = write that bit)
- A  input  ADDR_W  word address
- D  input  DATA_W  write data
- Q  output  DATA_W  read data
- rvalid  output  1  one-cycle pulse; Q carries fresh read data
- ready  output  1  high when requests are accepted
- err  output  1  one-cycle pulse; accepted access had A >= DEPTH

Behaviour:
- Reset (rst=1, async):
  - state=INIT, clear counter=0
  - ready=0, rvalid=0, err=0, Q=0
  - read pipeline flushed
  - array contents not touched while rst is held
- States: INIT, RUN.
- INIT:
  - Each cycle after rst deasserts, writes INIT_VAL to ram[cnt], then cnt++.
  - After the write of address DEPTH-1, moves to RUN. ready=1 from the following cycle.
  - INIT therefore lasts exactly DEPTH cycles.
  - CEN/WEN/A/D/BWEN are ignored in INIT: no write, no rvalid, no err.
- RUN: an access is accepted on a posedge with ready=1 and CEN=0.
  - Write (WEN=0): ram[A] <= (D & ~BWEN) | (ram[A] & BWEN). BWEN all-ones is a legal no-op write. No rvalid.
  - Read (WEN=1):
    - RD_LAT=1: Q=ram[A] and rvalid=1 in the cycle after the accept edge.
    - RD_LAT=2: one cycle later.
    - Back-to-back reads give back-to-back rvalid with no bubbles; throughput 1/cycle.
  - Q holds its last read value when no read completes. Never random, never cleared except by rst.
  - A >= DEPTH:
    - write is dropped, array unchanged
    - read returns Q=0 with rvalid, on the same latency as a normal read
    - err pulses one cycle, aligned with the accept edge +1, for both reads and writes
  - Read of the address written on the previous accepted cycle returns the new data: write completes at its edge, read samples at the next.
  - CEN=1: no access; WEN/A/D/BWEN don't-care.
- Reset mid-operation:
  - in-flight reads are discarded; no rvalid emitted after rst
  - sequencer restarts at address 0 and re-clears the whole array
- ready never drops in RUN except via rst.

Test Plan:
- Init: DEPTH=64, INIT_VAL=0xA5 replicated. Release rst. Hold CEN=0, WEN=0, D=all-ones throughout.
  -> ready rises exactly 64 cycles after release. Subsequent reads of addr 0, 31, 63 return INIT_VAL, proving INIT ignored the writes.
- Bit-mask write: write addr 5 D=all-ones, BWEN=all-ones except bits[7:0]=0, over INIT_VAL=0. Then read addr 5.
  -> Q=0x...00FF (only low byte set). rvalid at +1 (RD_LAT=1) or +2 (RD_LAT=2).
- Streaming read: write addrs 0..7 with value=addr. Issue 8 consecutive reads 0..7.
  -> rvalid high 8 consecutive cycles, Q=0..7 in order. Q holds 7 afterwards with rvalid=0.
- Write-then-read same address: write addr 9 = 0x1234, next cycle read addr 9.
  -> Q=0x1234.
- Out of range: DEPTH=48, ADDR_W=6. Write addr 50, then read addr 50 and read addr 47.
  -> err pulses for both accesses at addr 50. Read of 50 returns Q=0 with rvalid. Addr 47 unchanged (INIT_VAL).
- Reset mid-stream: RD_LAT=2, issue read, assert rst one cycle later.
  -> no rvalid ever appears for that read. Q=0. ready=0 for DEPTH cycles after release. Array re-cleared to INIT_VAL.

Source files
------------

// File: rtl/sram_sp_bw_init.sv
`default_nettype none
// ============================================================================
// sram_sp_bw_init : single-port bit-write SRAM model with power-on clear
// Revision 1.0
// ============================================================================
module sram_sp_bw_init #(
    parameter int                DATA_W   = 128,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 6,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [DATA_W-1:0] BWEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    output logic              rvalid,
    output logic              ready,
    output logic              err
);

    localparam logic [0:0]        S_INIT    = 1'b0;
    localparam logic [0:0]        S_RUN     = 1'b1;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("sram_sp_bw_init: RD_LAT must be 1 or 2");
        end
        if ((1 << ADDR_W) < DEPTH) begin : g_bad_addr_w
            $error("sram_sp_bw_init: ADDR_W too narrow for DEPTH");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] q_q;
    logic              rvalid_q, err_q;
    logic              pv_q;
    logic [DATA_W-1:0] pd_q;

    logic              accept;
    logic              in_range;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_data;

    assign ready    = (state_q == S_RUN);
    assign accept   = ready && !CEN;
    assign in_range = ({1'b0, A} < DEPTH_W);
    assign rd_fire  = accept && WEN;
    assign rd_data  = in_range ? mem_q[A] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            q_q      <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            pv_q     <= 1'b0;
            pd_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= accept && !in_range;
            pv_q    <= rd_fire;
            if (rd_fire) begin
                pd_q <= rd_data;
            end
            // Q only moves when a read completes; otherwise it holds the last read.
            if (RD_LAT == 1) begin
                rvalid_q <= rd_fire;
                if (rd_fire) begin
                    q_q <= rd_data;
                end
            end else begin
                rvalid_q <= pv_q;
                if (pv_q) begin
                    q_q <= pd_q;
                end
            end
        end
    end

    // Array has no reset value; rst only freezes it so contents survive until re-cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_q[cnt_q] <= INIT_VAL;
            end else if (accept && !WEN && in_range) begin
                mem_q[A] <= (D & ~BWEN) | (mem_q[A] & BWEN);
            end
        end
    end

    assign Q      = q_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_bw_init.sv
`default_nettype none
// tb_sram_sp_bw_init : two geometries (64/lat1, 48/lat2) driven together and
// compared every cycle against an array-based reference model.
module tb_sram_sp_bw_init;

    localparam int            NI  = 2;
    localparam int            DW  = 128;
    localparam int            AW  = 6;
    localparam logic [DW-1:0] IV0 = {16{8'hA5}};
    localparam logic [DW-1:0] IV1 = '0;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          cen  = 1'b1;
    logic          wen  = 1'b1;
    logic [DW-1:0] bwen = '1;
    logic [DW-1:0] d    = '0;
    logic [AW-1:0] a    = '0;
    logic [DW-1:0] q   [NI];
    logic          rv  [NI];
    logic          rdy [NI];
    logic          er  [NI];

    always #5 clk = ~clk;

    sram_sp_bw_init #(
        .DATA_W(DW), .DEPTH(64), .ADDR_W(AW), .RD_LAT(1), .INIT_VAL(IV0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
        .Q(q[0]), .rvalid(rv[0]), .ready(rdy[0]), .err(er[0])
    );

    sram_sp_bw_init #(
        .DATA_W(DW), .DEPTH(48), .ADDR_W(AW), .RD_LAT(2), .INIT_VAL(IV1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
        .Q(q[1]), .rvalid(rv[1]), .ready(rdy[1]), .err(er[1])
    );

    int            depth [NI] = '{64, 48};
    int            lat   [NI] = '{1, 2};
    logic [DW-1:0] ival  [NI];
    logic [DW-1:0] mref  [NI][64];
    int            init_left [NI];
    logic [DW-1:0] q_exp   [NI];
    logic          rv_exp  [NI];
    logic          err_exp [NI];
    bit            slot_v [NI][4];
    logic [DW-1:0] slot_d [NI][4];
    int            n        = 0;
    int            checks   = 0;
    int            failures = 0;

    task automatic model_edge();
        int ai;
        int slot;
        bit oob;
        n++;
        ai = int'(a);
        for (int i = 0; i < NI; i++) begin
            rv_exp[i]  = 1'b0;
            err_exp[i] = 1'b0;
            if (!rst) begin
                if (init_left[i] > 0) begin
                    mref[i][depth[i] - init_left[i]] = ival[i];
                    init_left[i]--;
                end else if (!cen) begin
                    oob        = (ai >= depth[i]);
                    err_exp[i] = oob;
                    if (!wen) begin
                        if (!oob) mref[i][ai] = (d & ~bwen) | (mref[i][ai] & bwen);
                    end else begin
                        slot            = (n + lat[i] - 1) % 4;
                        slot_v[i][slot] = 1'b1;
                        slot_d[i][slot] = oob ? '0 : mref[i][ai];
                    end
                end
                if (slot_v[i][n % 4]) begin
                    rv_exp[i]         = 1'b1;
                    q_exp[i]          = slot_d[i][n % 4];
                    slot_v[i][n % 4]  = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(string tag, int i, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic check_all();
        logic rdy_e;
        for (int i = 0; i < NI; i++) begin
            rdy_e = !rst && (init_left[i] == 0);
            chk("ready",  i, DW'(rdy[i]), DW'(rdy_e));
            chk("rvalid", i, DW'(rv[i]),  DW'(rv_exp[i]));
            chk("err",    i, DW'(er[i]),  DW'(err_exp[i]));
            chk("Q",      i, q[i],        q_exp[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(logic c, logic w, int addr, logic [DW-1:0] data, logic [DW-1:0] mask);
        cen  = c;
        wen  = w;
        a    = AW'(addr);
        d    = data;
        bwen = mask;
        step();
    endtask

    task automatic idle(int cycles);
        cen = 1'b1;
        repeat (cycles) step();
    endtask

    task automatic do_reset(int hold);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            init_left[i] = depth[i];
            q_exp[i]     = '0;
            rv_exp[i]    = 1'b0;
            err_exp[i]   = 1'b0;
            for (int s = 0; s < 4; s++) slot_v[i][s] = 1'b0;
        end
        check_all();
        repeat (hold) step();
        rst = 1'b0;
    endtask

    initial begin
        ival[0] = IV0;
        ival[1] = IV1;

        // Power-on clear while the bus tries to write all-ones everywhere
        cen = 1'b0; wen = 1'b0; d = '1; bwen = '0; a = AW'(5);
        do_reset(3);
        repeat (64) step();
        drive(1'b0, 1'b1, 0,  '0, '1);
        drive(1'b0, 1'b1, 31, '0, '1);
        drive(1'b0, 1'b1, 63, '0, '1);
        idle(2);

        // Masked write: only the low byte lands
        drive(1'b0, 1'b0, 5, '1, ~(DW'(8'hFF)));
        drive(1'b0, 1'b1, 5, '0, '1);
        idle(3);

        // Streaming reads after writing value=addr
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, i, DW'(i), '0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, i, '0, '1);
        idle(3);

        // Write immediately followed by read of the same word
        drive(1'b0, 1'b0, 9, DW'(16'h1234), '0);
        drive(1'b0, 1'b1, 9, '0, '1);
        idle(2);

        // Out-of-range for the 48-deep instance
        drive(1'b0, 1'b0, 50, {$urandom, $urandom, $urandom, $urandom}, '0);
        drive(1'b0, 1'b1, 50, '0, '1);
        drive(1'b0, 1'b1, 47, '0, '1);
        idle(2);

        for (int k = 0; k < 400; k++) begin
            int            m;
            logic [DW-1:0] msk;
            m   = $urandom_range(0, 2);
            msk = (m == 0) ? '1 : (m == 1) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 63), {$urandom, $urandom, $urandom, $urandom}, msk);
        end
        idle(2);

        // Reset one cycle after a read is accepted; the lat-2 result must vanish
        drive(1'b0, 1'b1, 5, '0, '1);
        cen = 1'b1;
        do_reset(2);
        repeat (64) step();
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, i, '0, '1);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
